// File: rtl/rv_sim_mem_mmio_if.sv
// Fetch/data/MMIO bundle between rv_cpu (master) and the sim memory (slave).
// Signal names keep the CPU-facing _i/_o suffixes of the memory model.
interface rv_sim_mem_mmio_if;
  logic [31:0] im_addr_i;
  logic [31:0] im_data_o;
  logic        im_valid_o;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_store_i;
  logic        dm_load_i;
  logic        dm_ready_o;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        console_valid_o;
  logic [7:0]  console_char_o;
  logic        test_done_o;
  logic [31:0] test_code_o;
  logic [31:0] cycle_count_o;

  modport master (
    output im_addr_i,
    output dm_addr_i,
    output dm_data_s_i,
    output dm_data_select_i,
    output dm_store_i,
    output dm_load_i,
    input  im_data_o,
    input  im_valid_o,
    input  dm_ready_o,
    input  dm_data_l_o,
    input  dm_load_done_o,
    input  dm_store_done_o,
    input  console_valid_o,
    input  console_char_o,
    input  test_done_o,
    input  test_code_o,
    input  cycle_count_o
  );

  modport slave (
    input  im_addr_i,
    input  dm_addr_i,
    input  dm_data_s_i,
    input  dm_data_select_i,
    input  dm_store_i,
    input  dm_load_i,
    output im_data_o,
    output im_valid_o,
    output dm_ready_o,
    output dm_data_l_o,
    output dm_load_done_o,
    output dm_store_done_o,
    output console_valid_o,
    output console_char_o,
    output test_done_o,
    output test_code_o,
    output cycle_count_o
  );
endinterface

// File: rtl/rv_sim_mem_mmio.sv
// Unified sim RAM for rv_cpu benches: LFSR wait-states, load pipe, MMIO.
// Ports: clk_i, rst_i (sync, active high), bus (rv_sim_mem_mmio_if.slave).
module rv_sim_mem_mmio #(
  parameter int          MEM_WORDS    = 16384,
  parameter int          DM_LOAD_LAT  = 1,
  parameter int          STALL_THRESH = 0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [31:0] MMIO_BASE    = 32'h0010_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  rv_sim_mem_mmio_if.slave bus
);

  localparam int          AW    = $clog2(MEM_WORDS);
  localparam int          LAT   = DM_LOAD_LAT;
  localparam logic [15:0] SEED  =
    (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
  localparam logic [8:0]  THR   = 9'(STALL_THRESH);
  localparam logic [29:0] MWORD = MMIO_BASE[31:2];
  localparam logic [29:0] MSPAN = 30'd16;

  logic [31:0] mem [MEM_WORDS];

  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic        im_stall;

  logic [29:0]   dm_word;
  logic [29:0]   moff;
  logic          is_mmio;
  logic [AW-1:0] dm_idx;
  logic [AW-1:0] im_idx;

  logic        acc_st;
  logic        acc_ld;
  logic        st_ram;
  logic        st_con;
  logic        st_stat;
  logic [31:0] rd_data;

  logic [LAT-1:0] pv;
  logic [31:0]    pd  [LAT];
  logic [LAT-1:0] vin;
  logic [31:0]    din [LAT];

  logic unused_bits;

  // Right-shift Galois form of x^16+x^14+x^13+x^11+1.
  assign lfsr_nxt =
    {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign im_stall = {1'b0, lfsr[7:0]} < THR;

  assign dm_word = bus.dm_addr_i[31:2];
  assign moff    = dm_word - MWORD;
  assign is_mmio = moff < MSPAN;
  assign dm_idx  = dm_word[AW-1:0];
  assign im_idx  = bus.im_addr_i[AW+1:2];

  // Store beats load when both are raised.
  assign acc_st  = bus.dm_ready_o & bus.dm_store_i;
  assign acc_ld  = bus.dm_ready_o & bus.dm_load_i & ~bus.dm_store_i;
  assign st_ram  = acc_st & ~is_mmio;
  assign st_con  = acc_st & is_mmio & (moff == 30'd0);
  assign st_stat = acc_st & is_mmio & (moff == 30'd1);

  always_comb begin
    rd_data = '0;
    if (is_mmio) begin
      if (moff == 30'd2)
        rd_data = bus.cycle_count_o;
    end else begin
      rd_data = mem[dm_idx];
    end
  end

  // Stage i takes stage i-1; stage 0 takes the accepted load.
  always_comb begin
    vin[0] = acc_ld;
    din[0] = rd_data;
    for (int i = 1; i < LAT; i++) begin
      vin[i] = pv[i-1];
      din[i] = pd[i-1];
    end
  end

  assign bus.dm_load_done_o = pv[LAT-1];
  assign bus.dm_data_l_o    = pd[LAT-1];

  // RAM has no reset; old contents survive for post-mortem reads.
  always_ff @(posedge clk_i) begin
    if (!rst_i && st_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.dm_data_select_i[b])
          mem[dm_idx][8*b +: 8] <= bus.dm_data_s_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr                <= SEED;
      bus.im_data_o       <= '0;
      bus.im_valid_o      <= 1'b0;
      bus.dm_ready_o      <= 1'b0;
      bus.dm_store_done_o <= 1'b0;
      bus.console_valid_o <= 1'b0;
      bus.console_char_o  <= '0;
      bus.test_done_o     <= 1'b0;
      bus.test_code_o     <= '0;
      bus.cycle_count_o   <= '0;
      pv                  <= '0;
      for (int i = 0; i < LAT; i++)
        pd[i] <= '0;
    end else begin
      lfsr           <= lfsr_nxt;
      bus.dm_ready_o <= !({1'b0, lfsr[15:8]} < THR);

      // Fetch reads the pre-edge RAM, so a same-edge store is not seen.
      if (!im_stall) begin
        bus.im_data_o  <= mem[im_idx];
        bus.im_valid_o <= 1'b1;
      end else begin
        bus.im_valid_o <= 1'b0;
      end

      bus.dm_store_done_o <= acc_st;
      bus.console_valid_o <= st_con;
      if (st_con)
        bus.console_char_o <= bus.dm_data_s_i[7:0];

      if (st_stat) begin
        bus.test_code_o <= bus.dm_data_s_i;
        bus.test_done_o <= 1'b1;
      end

      if (!bus.test_done_o)
        bus.cycle_count_o <= bus.cycle_count_o + 32'd1;

      pv <= vin;
      for (int i = 0; i < LAT; i++) begin
        if (vin[i])
          pd[i] <= din[i];
      end
    end
  end

  assign unused_bits = ^{bus.im_addr_i[31:AW+2], bus.im_addr_i[1:0],
                         bus.dm_addr_i[1:0]};

endmodule

// File: tb/tb_rv_sim_mem_mmio.sv
// Bench for rv_sim_mem_mmio: two instances (no-stall LAT=3, stall LAT=4).
// Scoreboard queues hold expected load data popped on dm_load_done_o.
module tb_rv_sim_mem_mmio;

  logic clk;
  logic rst0;
  logic rst1;

  int checks;
  int failures;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  logic [31:0] m0;
  logic        frz0;

  rv_sim_mem_mmio_if b0 ();
  rv_sim_mem_mmio_if b1 ();

  rv_sim_mem_mmio #(
    .MEM_WORDS(1024), .DM_LOAD_LAT(3), .STALL_THRESH(0)
  ) u0 (.clk_i(clk), .rst_i(rst0), .bus(b0));

  rv_sim_mem_mmio #(
    .MEM_WORDS(1024), .DM_LOAD_LAT(4), .STALL_THRESH(128)
  ) u1 (.clk_i(clk), .rst_i(rst1), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent cycle counter for u0.
  always @(posedge clk) begin
    if (rst0) m0 <= '0;
    else if (!frz0) m0 <= m0 + 32'd1;
  end

  task automatic idle0();
    b0.dm_store_i = 1'b0;
    b0.dm_load_i  = 1'b0;
  endtask

  task automatic store0(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    b0.dm_addr_i = a;
    b0.dm_data_s_i = d;
    b0.dm_data_select_i = s;
    b0.dm_store_i = 1'b1;
    b0.dm_load_i = 1'b0;
    @(negedge clk);
    idle0();
  endtask

  task automatic load0(input logic [31:0] a);
    b0.dm_addr_i = a;
    b0.dm_load_i = 1'b1;
    b0.dm_store_i = 1'b0;
    @(negedge clk);
    idle0();
  endtask

  task automatic test_reset();
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({b0.im_data_o, b0.dm_data_l_o, b0.test_code_o,
         b0.cycle_count_o} !== 128'd0) begin
      failures++;
      $display("FAIL rst_words got=%h %h %h %h exp=0", b0.im_data_o,
               b0.dm_data_l_o, b0.test_code_o, b0.cycle_count_o);
    end
    checks++;
    if ({b0.im_valid_o, b0.dm_ready_o, b0.dm_load_done_o,
         b0.dm_store_done_o, b0.console_valid_o, b0.console_char_o,
         b0.test_done_o} !== 14'd0) begin
      failures++;
      $display("FAIL rst_flags got=%b exp=0",
               {b0.im_valid_o, b0.dm_ready_o, b0.dm_load_done_o,
                b0.dm_store_done_o, b0.console_valid_o, b0.test_done_o});
    end
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    checks++;
    if (b0.cycle_count_o !== 32'd1 || m0 !== 32'd1) begin
      failures++;
      $display("FAIL cc_first got=%0d exp=1", b0.cycle_count_o);
    end
    checks++;
    if (b0.dm_ready_o !== 1'b1 || b0.im_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL ready_first got=%b%b exp=11",
               b0.dm_ready_o, b0.im_valid_o);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] exp [3];
    exp[0] = 32'h11;
    exp[1] = 32'h22;
    exp[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      store0(32'(4 * i), exp[i], 4'hF);
      checks++;
      if (b0.dm_store_done_o !== 1'b1) begin
        failures++;
        $display("FAIL pre_st_done[%0d] got=%b exp=1", i,
                 b0.dm_store_done_o);
      end
    end
    for (int i = 0; i < 3; i++) begin
      b0.im_addr_i = 32'(4 * i);
      @(negedge clk);
      checks++;
      if (b0.im_valid_o !== 1'b1 || b0.im_data_o !== exp[i]) begin
        failures++;
        $display("FAIL fetch[%0d] got=%b/%h exp=1/%h", i,
                 b0.im_valid_o, b0.im_data_o, exp[i]);
      end
    end
    store0(32'h50, 32'hDEAD_0001, 4'hF);
    b0.im_addr_i = 32'h50;
    store0(32'h50, 32'hBEEF_0002, 4'hF);
    checks++;
    if (b0.im_data_o !== 32'hDEAD_0001) begin
      failures++;
      $display("FAIL fetch_before_store got=%h exp=dead0001",
               b0.im_data_o);
    end
    b0.im_addr_i = 32'h50 + 32'd4096;
    @(negedge clk);
    checks++;
    if (b0.im_data_o !== 32'hBEEF_0002) begin
      failures++;
      $display("FAIL fetch_alias got=%h exp=beef0002", b0.im_data_o);
    end
  endtask

  task automatic test_store_load();
    int got;
    logic [31:0] e;
    store0(32'h40, 32'hFFFF_FFFF, 4'hF);
    store0(32'h40, 32'hA5A5_A5A5, 4'b0101);
    checks++;
    if (b0.dm_store_done_o !== 1'b1) begin
      failures++;
      $display("FAIL st_done got=%b exp=1", b0.dm_store_done_o);
    end
    @(negedge clk);
    checks++;
    if (b0.dm_store_done_o !== 1'b0) begin
      failures++;
      $display("FAIL st_done_pulse got=%b exp=0", b0.dm_store_done_o);
    end
    load0(32'h40);
    q0.push_back(32'hFFA5_FFA5);
    got = 0;
    for (int k = 1; k <= 6; k++) begin
      if (b0.dm_load_done_o) begin
        checks++;
        got++;
        e = (q0.size() != 0) ? q0.pop_front() : 32'hX;
        if (b0.dm_data_l_o !== e || k != 3) begin
          failures++;
          $display("FAIL ld_lat got=%h@%0d exp=%h@3",
                   b0.dm_data_l_o, k, e);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (got != 1 || b0.dm_data_l_o !== 32'hFFA5_FFA5) begin
      failures++;
      $display("FAIL ld_hold got=%0d/%h exp=1/ffa5ffa5",
               got, b0.dm_data_l_o);
    end
  endtask

  task automatic test_back_to_back();
    int got;
    logic [31:0] e;
    got = 0;
    for (int c = 0; c < 9; c++) begin
      if (b0.dm_load_done_o) begin
        checks++;
        got++;
        e = (q0.size() != 0) ? q0.pop_front() : 32'hX;
        if (b0.dm_data_l_o !== e) begin
          failures++;
          $display("FAIL b2b[%0d] got=%h exp=%h", got,
                   b0.dm_data_l_o, e);
        end
      end
      if (c < 3) begin
        b0.dm_addr_i = 32'(4 * c);
        b0.dm_load_i = 1'b1;
        q0.push_back(32'(32'h11 * (c + 1)));
      end else begin
        idle0();
      end
      @(negedge clk);
    end
    checks++;
    if (got != 3 || q0.size() != 0) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", got);
    end
  endtask

  task automatic test_console();
    int got;
    logic [31:0] e;
    store0(32'h0010_0000, 32'h4F, 4'hF);
    checks++;
    if (b0.console_valid_o !== 1'b1 || b0.console_char_o !== 8'h4F) begin
      failures++;
      $display("FAIL con_o got=%b/%h exp=1/4f",
               b0.console_valid_o, b0.console_char_o);
    end
    @(negedge clk);
    checks++;
    if (b0.console_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL con_pulse got=%b exp=0", b0.console_valid_o);
    end
    store0(32'h0010_0000, 32'h4B, 4'hF);
    checks++;
    if (b0.console_valid_o !== 1'b1 || b0.console_char_o !== 8'h4B) begin
      failures++;
      $display("FAIL con_k got=%b/%h exp=1/4b",
               b0.console_valid_o, b0.console_char_o);
    end
    b0.im_addr_i = 32'h0;
    @(negedge clk);
    checks++;
    if (b0.im_data_o !== 32'h11) begin
      failures++;
      $display("FAIL mmio_no_ram got=%h exp=11", b0.im_data_o);
    end
    load0(32'h0010_000C);
    q0.push_back(32'h0);
    got = 0;
    for (int k = 1; k <= 6; k++) begin
      if (b0.dm_load_done_o) begin
        checks++;
        got++;
        e = (q0.size() != 0) ? q0.pop_front() : 32'hX;
        if (b0.dm_data_l_o !== e) begin
          failures++;
          $display("FAIL mmio_other got=%h exp=%h", b0.dm_data_l_o, e);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (got != 1) begin
      failures++;
      $display("FAIL mmio_other_cnt got=%0d exp=1", got);
    end
  endtask

  task automatic test_status();
    int n;
    int got;
    logic [31:0] e;
    n = 0;
    while (m0 < 32'd499 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    store0(32'h0010_0004, 32'h0, 4'hF);
    frz0 = 1'b1;
    checks++;
    if (b0.test_done_o !== 1'b1 || b0.test_code_o !== 32'h0 ||
        b0.cycle_count_o !== m0 || m0 !== 32'd500) begin
      failures++;
      $display("FAIL status got=%b/%h/%0d exp=1/0/%0d", b0.test_done_o,
               b0.test_code_o, b0.cycle_count_o, m0);
    end
    store0(32'h0010_0008, 32'd123, 4'hF);
    repeat (4) @(negedge clk);
    checks++;
    if (b0.cycle_count_o !== m0 || b0.test_done_o !== 1'b1) begin
      failures++;
      $display("FAIL cc_frozen got=%0d exp=%0d",
               b0.cycle_count_o, m0);
    end
    load0(32'h0010_0008);
    q0.push_back(m0);
    got = 0;
    for (int k = 1; k <= 6; k++) begin
      if (b0.dm_load_done_o) begin
        checks++;
        got++;
        e = (q0.size() != 0) ? q0.pop_front() : 32'hX;
        if (b0.dm_data_l_o !== e) begin
          failures++;
          $display("FAIL cc_load got=%0d exp=%0d", b0.dm_data_l_o, e);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (got != 1) begin
      failures++;
      $display("FAIL cc_load_cnt got=%0d exp=1", got);
    end
  endtask

  task automatic test_random();
    logic [31:0] sh [32];
    int nacc;
    int ninit;
    int cyc;
    int op;
    int w;
    logic rdy;
    logic exp_sd;
    logic [31:0] d;
    logic [3:0] s;
    logic [31:0] e;
    nacc = 0;
    ninit = 0;
    cyc = 0;
    exp_sd = 1'b0;
    while ((nacc < 1032 || cyc < 1040) && cyc < 20000) begin
      checks++;
      if (b1.dm_store_done_o !== exp_sd) begin
        failures++;
        $display("FAIL rnd_st_done c=%0d got=%b exp=%b", cyc,
                 b1.dm_store_done_o, exp_sd);
      end
      if (b1.dm_load_done_o) begin
        checks++;
        e = (q1.size() != 0) ? q1.pop_front() : 32'hX;
        if (b1.dm_data_l_o !== e) begin
          failures++;
          $display("FAIL rnd_load c=%0d got=%h exp=%h", cyc,
                   b1.dm_data_l_o, e);
        end
      end
      rdy = b1.dm_ready_o;
      if (nacc >= 1032) begin
        op = 0;
      end else if (ninit < 32) begin
        op = 2;
      end else begin
        op = $urandom_range(0, 3);
      end
      w = (ninit < 32) ? ninit : $urandom_range(0, 31);
      d = $urandom;
      s = (ninit < 32) ? 4'hF : 4'($urandom_range(0, 15));
      b1.dm_addr_i = 32'h2000 + 32'(4 * w);
      b1.dm_data_s_i = d;
      b1.dm_data_select_i = s;
      b1.dm_load_i = (op == 1 || op == 3);
      b1.dm_store_i = (op >= 2);
      exp_sd = rdy && (op >= 2);
      if (rdy && op != 0) begin
        nacc++;
        if (op >= 2) begin
          for (int b = 0; b < 4; b++)
            if (s[b]) sh[w][8*b +: 8] = d[8*b +: 8];
          if (ninit < 32) ninit++;
        end else begin
          q1.push_back(sh[w]);
        end
      end
      @(negedge clk);
      cyc++;
    end
    b1.dm_load_i = 1'b0;
    b1.dm_store_i = 1'b0;
    checks++;
    if (q1.size() != 0 || nacc < 1032) begin
      failures++;
      $display("FAIL rnd_drain got=%0d/%0d exp=0/1032",
               q1.size(), nacc);
    end
  endtask

  task automatic test_reset_inflight();
    int n;
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      n = 0;
      while (!b1.dm_ready_o && n < 100) begin
        @(negedge clk);
        n++;
      end
      b1.dm_addr_i = 32'h2000;
      b1.dm_load_i = 1'b1;
      b1.dm_store_i = 1'b0;
      @(negedge clk);
      if (b1.dm_ready_o) begin
        @(negedge clk);
        b1.dm_load_i = 1'b0;
        rst1 = 1'b1;
        @(negedge clk);
        ok = 1'b1;
      end else begin
        b1.dm_load_i = 1'b0;
        repeat (8) @(negedge clk);
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rst_inflight_setup got=0 exp=1");
    end
    checks++;
    if ({b1.im_data_o, b1.dm_data_l_o, b1.test_code_o,
         b1.cycle_count_o, b1.im_valid_o, b1.dm_ready_o,
         b1.dm_load_done_o, b1.dm_store_done_o, b1.console_valid_o,
         b1.console_char_o, b1.test_done_o} !== 142'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%h/%b/%0d exp=0",
               b1.dm_data_l_o, b1.dm_load_done_o, b1.cycle_count_o);
    end
    rst1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (b1.dm_load_done_o !== 1'b0) begin
        failures++;
        $display("FAIL rst_no_done[%0d] got=1 exp=0", k);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    frz0 = 1'b0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    b0.im_addr_i = '0;
    b0.dm_addr_i = '0;
    b0.dm_data_s_i = '0;
    b0.dm_data_select_i = '0;
    b0.dm_store_i = 1'b0;
    b0.dm_load_i = 1'b0;
    b1.im_addr_i = '0;
    b1.dm_addr_i = '0;
    b1.dm_data_s_i = '0;
    b1.dm_data_select_i = '0;
    b1.dm_store_i = 1'b0;
    b1.dm_load_i = 1'b0;
    test_reset();
    test_fetch();
    test_store_load();
    test_back_to_back();
    test_console();
    test_status();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
